gpio_in_qualifier: RTL and testbench
====================================

# gpio_in_qualifier

Input-side qualification stage that sits directly downstream of the pinmux pad cell and consumes its raw pad input, in the same position as `async_in_from_pad_mscbus` / `GP_DATA_IN_out_mscbus`. It does three things to the asynchronous pad level:

- synchronizes it into the `i_clk` domain;
- applies a programmable stability-count glitch filter;
- detects qualified rising and falling edges.

It also keeps a sticky event flag and an overflow flag for the GPIO interrupt logic.

## Interface
Parameters:
- `CNT_WIDTH`, default 8: width of the filter length and of the qualification counter.
- `SYNC_STAGES`, default 2, minimum 2: flops in the input synchronizer chain.

Ports:
- `i_clk`  input  1  block clock; all state updates on its rising edge.
- `i_rst`  input  1  reset: synchronous, active-high, one clock domain.
- `i_pad_in`  input  1  asynchronous raw pad level from the pinmux input buffer.
- `i_en`  input  1  qualifier enable.
- `i_bypass`  input  1  1 = skip the filter; the qualified level follows the synchronized input.
- `i_filt_len`  input  CNT_WIDTH  N = number of consecutive differing cycles required to accept a new level.
- `i_edge_sel`  input  2  event select: 00 none, 01 rising, 10 falling, 11 both.
- `i_clr`  input  1  single-cycle pulse; clears `o_irq_flag` and `o_overflow`.
- `o_level`  output  1  qualified (filtered) level.
- `o_rise_pulse`  output  1  one-cycle pulse on a qualified 0→1 transition.
- `o_fall_pulse`  output  1  one-cycle pulse on a qualified 1→0 transition.
- `o_irq_flag`  output  1  sticky flag for the selected edge event.
- `o_overflow`  output  1  sticky flag: a selected event arrived while `o_irq_flag` was already set.

## Operation
- Synchronizer: `i_pad_in` passes through `SYNC_STAGES` flops; the last flop is `sync_q`. The synchronizer runs regardless of `i_en`.
- Filter FSM, two states:
  - STABLE: `sync_q == o_level` and `cnt == 0`.
  - QUALIFY: `sync_q != o_level`.
- Filter rules, evaluated at every rising edge of `i_clk`:
  - If `i_en == 0`: `cnt <= 0`; `o_level` holds; no pulses.
  - Else if `sync_q == o_level`: `cnt <= 0`; state is STABLE. A glitch shorter than N cycles is therefore discarded.
  - Else if `i_bypass == 1`, or N == 0, or `cnt >= N-1`: `o_level <= sync_q`; `cnt <= 0`; the matching edge pulse is asserted for exactly one cycle.
  - Else: `cnt <= cnt + 1`.
- Width and change rules:
  - The compare uses `>=`. A mid-qualify decrease of `i_filt_len` therefore qualifies on the next edge.
  - `cnt` never exceeds N-1 and never wraps.
- Pulses:
  - `o_rise_pulse` and `o_fall_pulse` are registered together with `o_level`, so each is high during the first cycle of the new level.
  - They are mutually exclusive.
  - They are generated irrespective of `i_edge_sel`.
- Event: `evt = (o_rise_pulse & i_edge_sel[0]) | (o_fall_pulse & i_edge_sel[1])`.
- Flag update, next edge:
  - If `evt` is set: `o_irq_flag <= 1`.
  - If `evt` is set and `o_irq_flag` is already 1: `o_overflow <= 1`.
  - Else, if `i_clr` is set: both flags <= 0.
- Simultaneous `evt` and `i_clr`:
  - `o_irq_flag` ends at 1 (set wins).
  - `o_overflow` is cleared (clear wins over the old value; no new overflow, because the clear consumes the prior flag).
- Flags hold while `i_en == 0`.

## Timing
- Reset: all synchronizer flops, `cnt`, `o_level`, `o_rise_pulse`, `o_fall_pulse`, `o_irq_flag` and `o_overflow` are 0 on the first edge with `i_rst = 1`.
- Reset mid-qualify aborts the count. `i_rst` has priority over all other inputs.
- Latency, pad step to `o_level` change:
  - `SYNC_STAGES` edges for synchronization, plus
  - N edges with N ≥ 1, or 1 edge with bypass or N == 0.
- Pulse-to-flag latency: `o_irq_flag` rises one cycle after the qualifying pulse.
- Enable: a change of `i_en` takes effect on the same edge; there is no handshake.
- Throughput:
  - Minimum qualified-edge spacing is max(N,1) cycles.
  - Back-to-back toggling on the synchronized input with N ≤ 1 yields a pulse every cycle.

## Test plan
- Reset, then hold `i_pad_in = 0` for 10 cycles → all outputs 0; `cnt` stays 0.
- `SYNC_STAGES = 2`, N = 4, `i_edge_sel = 01`, step the pad 0→1 → `o_level` rises exactly 6 edges after the step; `o_rise_pulse` is high for one cycle; `o_irq_flag` is 1 on the next cycle; `o_overflow` stays 0.
- N = 4, 3-cycle high glitch on the synchronized input → `o_level` stays 0; no pulse; `cnt` returns to 0.
- `i_edge_sel = 11`, N = 0: two qualified edges without a clear → `o_irq_flag = 1`, `o_overflow = 1`. Then `i_clr` alone → both 0.
- `i_clr` asserted on the same edge that `evt` is sampled, with `o_irq_flag` previously 1 → `o_irq_flag = 1`, `o_overflow = 0`.
- Mid-qualify (N = 8, `cnt = 5`):
  - `i_en` → 0: `cnt = 0`, `o_level` held.
  - Alternatively, `i_rst` pulse: all outputs 0 on the next edge.
  - Alternatively, `i_filt_len` → 3: `o_level` updates on the next edge.

Source files
------------

// File: rtl/gpio_in_qualifier_if.sv
// Control and status bundle between the GPIO pad qualifier and its controller.
// The slave side is the qualifier; the master side drives pad, enable and filter settings.
interface gpio_in_qualifier_if #(
  parameter int CNT_WIDTH = 8
);
  logic                 i_pad_in;
  logic                 i_en;
  logic                 i_bypass;
  logic [CNT_WIDTH-1:0] i_filt_len;
  logic [1:0]           i_edge_sel;
  logic                 i_clr;
  logic                 o_level;
  logic                 o_rise_pulse;
  logic                 o_fall_pulse;
  logic                 o_irq_flag;
  logic                 o_overflow;

  modport master (
    output i_pad_in, i_en, i_bypass, i_filt_len, i_edge_sel, i_clr,
    input  o_level, o_rise_pulse, o_fall_pulse, o_irq_flag, o_overflow
  );

  modport slave (
    input  i_pad_in, i_en, i_bypass, i_filt_len, i_edge_sel, i_clr,
    output o_level, o_rise_pulse, o_fall_pulse, o_irq_flag, o_overflow
  );
endinterface

// File: rtl/gpio_in_qualifier.sv
// Pad input qualifier: synchronizer, stability-count glitch filter, edge pulses
// and sticky event/overflow flags for the GPIO interrupt logic.
module gpio_in_qualifier #(
  parameter int CNT_WIDTH   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  gpio_in_qualifier_if.slave     bus
);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [SYNC_STAGES-1:0] sync_chain_q, sync_chain_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   irq_q, irq_d;
  logic                   ovf_q, ovf_d;
  logic                   sync_lvl;
  logic                   evt;
  logic                   accept;

  assign sync_lvl = sync_chain_q[SYNC_STAGES-1];
  assign evt      = (rise_q & bus.i_edge_sel[0]) | (fall_q & bus.i_edge_sel[1]);
  // Length 0 and bypass both accept on the first differing edge; the >= lets a
  // shortened length take effect immediately even if cnt is already past it.
  assign accept   = bus.i_bypass || (bus.i_filt_len == '0) ||
                    (cnt_q >= (bus.i_filt_len - CNT_ONE));

  always_comb begin
    sync_chain_d = {sync_chain_q[SYNC_STAGES-2:0], bus.i_pad_in};
    cnt_d        = cnt_q;
    level_d      = level_q;
    rise_d       = 1'b0;
    fall_d       = 1'b0;
    if (!bus.i_en) begin
      cnt_d = '0;
    end else if (sync_lvl == level_q) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d   = '0;
      level_d = sync_lvl;
      rise_d  = sync_lvl;
      fall_d  = ~sync_lvl;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_comb begin
    irq_d = irq_q;
    ovf_d = ovf_q;
    if (bus.i_en) begin
      if (evt) begin
        irq_d = 1'b1;
        // A coincident clear consumes the old flag, so it cannot overflow.
        ovf_d = bus.i_clr ? 1'b0 : (ovf_q | irq_q);
      end else if (bus.i_clr) begin
        irq_d = 1'b0;
        ovf_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_chain_q <= '0;
      cnt_q        <= '0;
      level_q      <= 1'b0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      irq_q        <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      sync_chain_q <= sync_chain_d;
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      rise_q       <= rise_d;
      fall_q       <= fall_d;
      irq_q        <= irq_d;
      ovf_q        <= ovf_d;
    end
  end

  assign bus.o_level      = level_q;
  assign bus.o_rise_pulse = rise_q;
  assign bus.o_fall_pulse = fall_q;
  assign bus.o_irq_flag   = irq_q;
  assign bus.o_overflow   = ovf_q;
endmodule

// File: tb/tb_gpio_in_qualifier.sv
// Directed bench for gpio_in_qualifier with a cycle-level reference model
// built from pad history and a run-length view of the filter.
module tb_gpio_in_qualifier;
  localparam int CW   = 8;
  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gpio_in_qualifier_if #(.CNT_WIDTH(CW)) bus ();

  gpio_in_qualifier #(.CNT_WIDTH(CW), .SYNC_STAGES(SYNC)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  // Reference model state
  bit hist[$];
  int m_run;
  bit m_level, m_rise, m_fall, m_irq, m_ovf;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
  endtask

  // Model: the synchronized level is the pad value seen SYNC edges ago; a new
  // level is accepted once it has differed for max(N,1) consecutive enabled edges.
  task automatic model_step();
    bit cur_sync, n_level, n_rise, n_fall, n_irq, n_ovf, evt;
    int need;
    if (rst) begin
      hist.delete();
      m_run = 0; m_level = 0; m_rise = 0; m_fall = 0; m_irq = 0; m_ovf = 0;
      return;
    end
    cur_sync = (hist.size() >= SYNC) ? hist[SYNC-1] : 1'b0;
    hist.push_front(bus.i_pad_in);
    if (hist.size() > SYNC) void'(hist.pop_back());
    n_level = m_level; n_rise = 0; n_fall = 0;
    n_irq = m_irq; n_ovf = m_ovf;
    if (bus.i_en) begin
      evt = (m_rise && bus.i_edge_sel[0]) || (m_fall && bus.i_edge_sel[1]);
      if (cur_sync == m_level) m_run = 0;
      else begin
        need = bus.i_bypass ? 1 : ((int'(bus.i_filt_len) < 1) ? 1 : int'(bus.i_filt_len));
        if (m_run + 1 >= need) begin
          n_level = cur_sync; n_rise = cur_sync; n_fall = !cur_sync; m_run = 0;
        end else m_run = m_run + 1;
      end
      if (evt) begin
        n_ovf = bus.i_clr ? 1'b0 : (m_irq || m_ovf);
        n_irq = 1'b1;
      end else if (bus.i_clr) begin
        n_irq = 0; n_ovf = 0;
      end
    end else begin
      m_run = 0;
    end
    m_level = n_level; m_rise = n_rise; m_fall = n_fall; m_irq = n_irq; m_ovf = n_ovf;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    chk("level", int'(bus.o_level),      int'(m_level));
    chk("rise",  int'(bus.o_rise_pulse), int'(m_rise));
    chk("fall",  int'(bus.o_fall_pulse), int'(m_fall));
    chk("irq",   int'(bus.o_irq_flag),   int'(m_irq));
    chk("ovf",   int'(bus.o_overflow),   int'(m_ovf));
    chk("cnt",   int'(dut.cnt_q),        m_run);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int seen;
    bus.i_pad_in = 0; bus.i_en = 1; bus.i_bypass = 0; bus.i_filt_len = 8'd4;
    bus.i_edge_sel = 2'b01; bus.i_clr = 0;
    rst = 1;
    ticks(2);
    rst = 0;

    // Idle after reset
    ticks(10);
    chk("idle_level", int'(bus.o_level), 0);
    chk("idle_irq", int'(bus.o_irq_flag), 0);
    chk("idle_cnt", int'(dut.cnt_q), 0);

    // Step 0->1 with N=4: level must rise on the 6th edge
    bus.i_pad_in = 1;
    seen = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (seen == 0 && bus.o_level) begin
        seen = i;
        chk("step_rise_pulse", int'(bus.o_rise_pulse), 1);
      end
    end
    chk("step_latency", seen, 6);
    chk("step_irq", int'(bus.o_irq_flag), 1);
    chk("step_ovf", int'(bus.o_overflow), 0);

    // Clear, go low (falling not selected), then a 3-cycle high glitch
    bus.i_clr = 1; tick(); bus.i_clr = 0;
    chk("clr_irq", int'(bus.o_irq_flag), 0);
    bus.i_pad_in = 0; ticks(8);
    chk("low_level", int'(bus.o_level), 0);
    chk("low_irq", int'(bus.o_irq_flag), 0);
    bus.i_pad_in = 1; ticks(3);
    bus.i_pad_in = 0; ticks(6);
    chk("glitch_level", int'(bus.o_level), 0);
    chk("glitch_cnt", int'(dut.cnt_q), 0);

    // Both edges, N=0: two events without clear -> overflow
    bus.i_edge_sel = 2'b11; bus.i_filt_len = 8'd0;
    bus.i_pad_in = 1; ticks(4);
    bus.i_pad_in = 0; ticks(4);
    chk("two_evt_irq", int'(bus.o_irq_flag), 1);
    chk("two_evt_ovf", int'(bus.o_overflow), 1);
    bus.i_clr = 1; tick(); bus.i_clr = 0;
    chk("clr_only_irq", int'(bus.o_irq_flag), 0);
    chk("clr_only_ovf", int'(bus.o_overflow), 0);

    // Clear coinciding with an event while the flag is already set
    bus.i_pad_in = 1; ticks(4);
    chk("pre_sim_irq", int'(bus.o_irq_flag), 1);
    bus.i_pad_in = 0; ticks(3);
    chk("sim_fall_pulse", int'(bus.o_fall_pulse), 1);
    bus.i_clr = 1; tick(); bus.i_clr = 0;
    chk("sim_irq", int'(bus.o_irq_flag), 1);
    chk("sim_ovf", int'(bus.o_overflow), 0);

    // Mid-qualify N=8: disable, then shorten the length
    bus.i_filt_len = 8'd8;
    bus.i_pad_in = 1; ticks(7);
    chk("mid_cnt5", int'(dut.cnt_q), 5);
    bus.i_en = 0; tick();
    chk("dis_cnt", int'(dut.cnt_q), 0);
    chk("dis_level", int'(bus.o_level), 0);
    bus.i_en = 1; ticks(5);
    chk("re_cnt5", int'(dut.cnt_q), 5);
    bus.i_filt_len = 8'd3; tick();
    chk("shorten_level", int'(bus.o_level), 1);
    chk("shorten_rise", int'(bus.o_rise_pulse), 1);

    // Mid-qualify reset
    bus.i_filt_len = 8'd8;
    bus.i_pad_in = 0; ticks(7);
    chk("mid2_cnt5", int'(dut.cnt_q), 5);
    rst = 1; tick(); rst = 0;
    chk("rst_level", int'(bus.o_level), 0);
    chk("rst_irq", int'(bus.o_irq_flag), 0);
    chk("rst_ovf", int'(bus.o_overflow), 0);
    chk("rst_cnt", int'(dut.cnt_q), 0);

    // Bypass with per-cycle toggling: a pulse every cycle once synchronized
    bus.i_bypass = 1;
    for (int i = 0; i < 12; i++) begin
      bus.i_pad_in = (i % 2 == 0);
      tick();
    end
    chk("bp_pulse", int'(bus.o_rise_pulse | bus.o_fall_pulse), 1);
    bus.i_bypass = 0; bus.i_pad_in = 0;
    ticks(6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
